// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operating mode encoding.
// Optional parity output of the top is controlled by SHIFT_REG_PARITY_EN.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/shift_cnt_sat.sv
// Saturating shift counter with a one-cycle done pulse on reaching MAX.
// clr has priority over inc; done is registered alongside the count.
module shift_cnt_sat #(
  parameter int MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       inc,
  output logic [$clog2(MAX+1)-1:0]   cnt,
  output logic                       done
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(MAX))) begin
      cnt_d  = cnt_q + CW'(1);
      // Pulse only on the step into saturation, never while parked there.
      done_d = (cnt_q == CW'(MAX - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold / shift-left / shift-right / parallel load with sync set.
// Define SHIFT_REG_PARITY_EN to add the combinational even-parity output par.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       set,
  input  logic                       en,
  input  mode_t                      mode,
  input  logic                       sin_l,
  input  logic                       sin_r,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_l,
  output logic                       sout_r,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
`ifdef SHIFT_REG_PARITY_EN
  output logic                       par,
`endif
  output logic                       cnt_done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             is_shift;
  logic             cnt_clr;

  always_comb begin
    q_d = q_q;
    if (set) begin
      q_d = SET_VAL;
    end else if (en) begin
      case (mode)
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
        MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
        MODE_LOAD: q_d = d;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  // set overrides any shift/load request, so it gates inc and forces clr.
  assign is_shift = !set && en && ((mode == MODE_SHL) || (mode == MODE_SHR));
  assign cnt_clr  = set || (en && (mode == MODE_LOAD));

  shift_cnt_sat #(.MAX(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (res),
    .clr  (cnt_clr),
    .inc  (is_shift),
    .cnt  (shift_cnt),
    .done (cnt_done)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

`ifdef SHIFT_REG_PARITY_EN
  assign par = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8).
// Parity checks are compiled in when SHIFT_REG_PARITY_EN is defined.
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       res;
  logic       set;
  logic       en;
  mode_t      mode;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] shift_cnt;
  logic       cnt_done;
`ifdef SHIFT_REG_PARITY_EN
  logic       par;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .res       (res),
    .set       (set),
    .en        (en),
    .mode      (mode),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .d         (d),
    .q         (q),
    .sout_l    (sout_l),
    .sout_r    (sout_r),
    .shift_cnt (shift_cnt),
`ifdef SHIFT_REG_PARITY_EN
    .par       (par),
`endif
    .cnt_done  (cnt_done)
  );

  always #5 clk = ~clk;

  // One active edge, then return to the sampling point at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic e, input mode_t m,
                       input logic sl, input logic sr, input logic [7:0] dv);
    set = s; en = e; mode = m; sin_l = sl; sin_r = sr; d = dv;
  endtask

  task automatic test_reset();
    tests_run++;
    if (q !== 8'h00 || shift_cnt !== 4'd0 || cnt_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_init q=%h cnt=%0d done=%b, want q=00 cnt=0 done=0", q, shift_cnt, cnt_done);
    end
`ifdef SHIFT_REG_PARITY_EN
    tests_run++;
    if (par !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_par par=%b want 0", par);
    end
`endif
    res = 1'b0;
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h4A);
    tick();
    drive(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b1, 8'h00);
    tick();
    tests_run++;
    if (q !== 8'hA5 || shift_cnt !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset q=%h cnt=%0d, want q=a5 cnt=1", q, shift_cnt);
    end
    #2 res = 1'b1;
    #1;
    tests_run++;
    if (q !== 8'h00 || shift_cnt !== 4'd0 || cnt_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset q=%h cnt=%0d done=%b, want q=00 cnt=0 done=0", q, shift_cnt, cnt_done);
    end
    drive(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    @(negedge clk);
    tick();
    tests_run++;
    if (q !== 8'h00 || shift_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_held q=%h cnt=%0d, want q=00 cnt=0", q, shift_cnt);
    end
    res = 1'b0;
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    tick();
    tests_run++;
    if (q !== 8'h3C || shift_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release q=%h cnt=%0d, want q=3c cnt=0", q, shift_cnt);
    end
  endtask

  task automatic test_shl();
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
    tick();
    tests_run++;
    if (q !== 8'h81 || sout_l !== 1'b1 || sout_r !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load_81 q=%h sl=%b sr=%b, want q=81 sl=1 sr=1", q, sout_l, sout_r);
    end
    drive(1'b0, 1'b1, MODE_SHL, 1'b0, 1'b1, 8'hFF);
    tick();
    tests_run++;
    if (q !== 8'h02 || sout_l !== 1'b0 || sout_r !== 1'b0 || shift_cnt !== 4'd1 || cnt_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL shl_one q=%h sl=%b sr=%b cnt=%0d done=%b, want q=02 sl=0 sr=0 cnt=1 done=0",
               q, sout_l, sout_r, shift_cnt, cnt_done);
    end
  endtask

  task automatic test_shr_saturate();
    logic [7:0] q_exp [1:8];
    q_exp = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h01);
    tick();
    drive(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      tick();
      tests_run++;
      if (q !== q_exp[i] || shift_cnt !== 4'(i) || cnt_done !== (i == 8)) begin
        tests_failed++;
        $display("[TB] FAIL shr_step%0d q=%h cnt=%0d done=%b, want q=%h cnt=%0d done=%b",
                 i, q, shift_cnt, cnt_done, q_exp[i], i, (i == 8));
      end
    end
    tick();
    tests_run++;
    if (q !== 8'hFF || shift_cnt !== 4'd8 || cnt_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL shr_saturated q=%h cnt=%0d done=%b, want q=ff cnt=8 done=0", q, shift_cnt, cnt_done);
    end
  endtask

  task automatic test_set_priority();
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h10);
    tick();
    drive(1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    drive(1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
    tick();
    tests_run++;
    if (q !== 8'hFF || shift_cnt !== 4'd0 || cnt_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL set_over_load q=%h cnt=%0d done=%b, want q=ff cnt=0 done=0", q, shift_cnt, cnt_done);
    end
    drive(1'b1, 1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
    tick();
    tests_run++;
    if (q !== 8'hFF || shift_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL set_over_shift q=%h cnt=%0d, want q=ff cnt=0", q, shift_cnt);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    tick();
    drive(1'b0, 1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, MODE_SHL, 1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (q !== 8'h79 || shift_cnt !== 4'd1 || cnt_done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL en_low_%0d q=%h cnt=%0d done=%b, want q=79 cnt=1 done=0", i, q, shift_cnt, cnt_done);
      end
    end
    drive(1'b0, 1'b1, MODE_HOLD, 1'b1, 1'b1, 8'hAA);
    tick();
    tests_run++;
    if (q !== 8'h79 || shift_cnt !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL mode_hold q=%h cnt=%0d, want q=79 cnt=1", q, shift_cnt);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h96);
    tick();
    drive(1'b0, 1'b1, MODE_SHL, 1'b1, 1'b1, 8'h00);
    tick();
    tests_run++;
    if (q !== 8'h2D || shift_cnt !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_shl q=%h cnt=%0d, want q=2d cnt=1", q, shift_cnt);
    end
    drive(1'b0, 1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
    tick();
    tests_run++;
    if (q !== 8'h16 || shift_cnt !== 4'd2 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_shr q=%h cnt=%0d sl=%b sr=%b, want q=16 cnt=2 sl=0 sr=0", q, shift_cnt, sout_l, sout_r);
    end
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hC3);
    tick();
    tests_run++;
    if (q !== 8'hC3 || shift_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_load q=%h cnt=%0d, want q=c3 cnt=0", q, shift_cnt);
    end
  endtask

`ifdef SHIFT_REG_PARITY_EN
  task automatic test_parity();
    drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h07);
    tick();
    tests_run++;
    if (par !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL par_07 par=%b want 1", par);
    end
    drive(1'b0, 1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    tick();
    tests_run++;
    if (q !== 8'h0F || par !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL par_0f q=%h par=%b, want q=0f par=0", q, par);
    end
  endtask
`endif

  initial begin
    res = 1'b1;
    drive(1'b0, 1'b0, MODE_HOLD, 1'b0, 1'b0, 8'h00);
    tick();
    test_reset();
    test_shl();
    test_shr_saturate();
    test_set_priority();
    test_hold();
    test_back_to_back();
`ifdef SHIFT_REG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
